project2_switches_pio_db: RTL and testbench

//  Parametrised Avalon-MM input PIO for board switches/keys: synchroniser, per-bit debounce,

---
 rtl/project2_switches_pio_db_if.sv | 19 +
 rtl/project2_switches_pio_db.sv | 108 ++++++++++
 tb/tb_project2_switches_pio_db.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/project2_switches_pio_db_if.sv
// Avalon-MM slave bus for the switch PIO: register access plus the level interrupt.
interface project2_switches_pio_db_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/project2_switches_pio_db.sv
// Input PIO for board switches: per-bit synchroniser, debounce, edge capture, masked level IRQ.
module project2_switches_pio_db #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned EDGE_TYPE       = 2
) (
  input logic                      clk,
  input logic                      reset,
  input logic [WIDTH-1:0]          in_port,
  project2_switches_pio_db_if.slave bus
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  typedef logic [CntW-1:0] cnt_t;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  cnt_t [WIDTH-1:0]                  cnt_q, cnt_d;
  logic [WIDTH-1:0]                  db_q, db_d;
  logic [WIDTH-1:0]                  mask_q, mask_d;
  logic [WIDTH-1:0]                  ec_q, ec_d;
  logic [31:0]                       readdata_q, readdata_d;

  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] edge_hit;
  logic             wr_en;

  assign sync  = sync_q[SYNC_STAGES-1];
  assign wr_en = bus.chipselect && !bus.write_n;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = in_port;
    for (int s = 1; s < int'(SYNC_STAGES); s++) begin
      sync_d[s] = sync_q[s-1];
    end

    cnt_d = cnt_q;
    db_d  = db_q;
    for (int b = 0; b < int'(WIDTH); b++) begin
      if (sync[b] == db_q[b]) begin
        cnt_d[b] = '0;
      end else if (cnt_q[b] == CntLast) begin
        db_d[b]  = sync[b];
        cnt_d[b] = '0;
      end else begin
        cnt_d[b] = cnt_q[b] + 1'b1;
      end
    end

    if (EDGE_TYPE == 0) begin
      edge_hit = db_d & ~db_q;
    end else if (EDGE_TYPE == 1) begin
      edge_hit = ~db_d & db_q;
    end else begin
      edge_hit = db_d ^ db_q;
    end

    mask_d = mask_q;
    if (wr_en && bus.address == 2'd2) begin
      mask_d = bus.writedata[WIDTH-1:0];
    end

    // Clear first, then OR in new edges so a same-cycle set beats the clear.
    ec_d = ec_q;
    if (wr_en && bus.address == 2'd3) begin
      ec_d = ec_q & ~bus.writedata[WIDTH-1:0];
    end
    ec_d = ec_d | edge_hit;

    // Read path ignores chipselect so latency is a fixed single cycle.
    unique case (bus.address)
      2'd0:    readdata_d = 32'(db_q);
      2'd1:    readdata_d = 32'(sync);
      2'd2:    readdata_d = 32'(mask_q);
      default: readdata_d = 32'(ec_q);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      db_q       <= '0;
      mask_q     <= '0;
      ec_q       <= '0;
      readdata_q <= '0;
    end else begin
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      db_q       <= db_d;
      mask_q     <= mask_d;
      ec_q       <= ec_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = |(ec_q & mask_q);

  if (WIDTH < 32) begin : g_unused_wd
    logic unused_wd;
    assign unused_wd = ^bus.writedata[31:WIDTH];
  end

endmodule

// File: tb/tb_project2_switches_pio_db.sv
// Bench for the switch PIO: scoreboard of expected bus values, one task per scenario.
module tb_project2_switches_pio_db;

  logic       clk;
  logic       rst0, rst1;
  logic [3:0] in0, in1;

  project2_switches_pio_db_if bus0 ();
  project2_switches_pio_db_if bus1 ();

  project2_switches_pio_db #(
    .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .EDGE_TYPE(2)
  ) dut0 (
    .clk(clk), .reset(rst0), .in_port(in0), .bus(bus0.slave)
  );

  project2_switches_pio_db #(
    .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .EDGE_TYPE(0)
  ) dut1 (
    .clk(clk), .reset(rst1), .in_port(in1), .bus(bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset0();
    rst0 = 1'b1;
    in0  = 4'h0;
    bus0.chipselect = 1'b0;
    bus0.write_n    = 1'b1;
    bus0.address    = 2'd0;
    bus0.writedata  = 32'h0;
    repeat (2) tick();
    rst0 = 1'b0;
  endtask

  task automatic reset1();
    rst1 = 1'b1;
    in1  = 4'h0;
    bus1.chipselect = 1'b0;
    bus1.write_n    = 1'b1;
    bus1.address    = 2'd0;
    bus1.writedata  = 32'h0;
    repeat (2) tick();
    rst1 = 1'b0;
  endtask

  task automatic write0(input logic [1:0] a, input logic [31:0] d);
    bus0.chipselect = 1'b1;
    bus0.write_n    = 1'b0;
    bus0.address    = a;
    bus0.writedata  = d;
    tick();
    bus0.chipselect = 1'b0;
    bus0.write_n    = 1'b1;
  endtask

  task automatic write1(input logic [1:0] a, input logic [31:0] d);
    bus1.chipselect = 1'b1;
    bus1.write_n    = 1'b0;
    bus1.address    = a;
    bus1.writedata  = d;
    tick();
    bus1.chipselect = 1'b0;
    bus1.write_n    = 1'b1;
  endtask

  task automatic test_reset();
    rst0 = 1'b1;
    in0  = 4'hF;
    bus0.chipselect = 1'b0;
    bus0.write_n    = 1'b1;
    bus0.address    = 2'd0;
    bus0.writedata  = 32'h0;
    repeat (3) tick();
    exp_q.push_back(32'h0);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (bus0.readdata !== exp_v) begin
      n_fail++;
      $display("FAIL reset_readdata: got %h want %h", bus0.readdata, exp_v);
    end
    n_cmp++;
    if (bus0.irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_irq: got %b want 0", bus0.irq);
    end
    rst0 = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      exp_q.push_back(k <= 10 ? 32'h0 : 32'hF);
      tick();
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (bus0.readdata !== exp_v) begin
        n_fail++;
        $display("FAIL reset_latency k=%0d: got %h want %h", k, bus0.readdata, exp_v);
      end
    end
  endtask

  task automatic test_glitch();
    reset0();
    bus0.address = 2'd1;
    in0 = 4'h1;
    for (int k = 1; k <= 12; k++) begin
      if (k == 6) in0 = 4'h0;
      exp_q.push_back((k >= 3 && k <= 7) ? 32'h1 : 32'h0);
      tick();
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (bus0.readdata !== exp_v || bus0.irq !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch_raw k=%0d: got %h irq %b want %h irq 0", k, bus0.readdata,
                 bus0.irq, exp_v);
      end
    end
    for (int a = 0; a < 4; a += 3) begin
      bus0.address = 2'(a);
      exp_q.push_back(32'h0);
      tick();
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (bus0.readdata !== exp_v) begin
        n_fail++;
        $display("FAIL glitch_reg%0d: got %h want %h", a, bus0.readdata, exp_v);
      end
    end
  endtask

  task automatic test_irq();
    reset0();
    write0(2'd2, 32'h1);
    bus0.address = 2'd2;
    exp_q.push_back(32'h1);
    tick();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (bus0.readdata !== exp_v) begin
      n_fail++;
      $display("FAIL irq_mask_read: got %h want %h", bus0.readdata, exp_v);
    end
    bus0.address = 2'd0;
    in0 = 4'h1;
    for (int k = 1; k <= 11; k++) begin
      exp_q.push_back({31'h0, k >= 10});
      exp_q.push_back(k >= 11 ? 32'h1 : 32'h0);
      tick();
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (bus0.irq !== exp_v[0]) begin
        n_fail++;
        $display("FAIL irq_rise k=%0d: got %b want %b", k, bus0.irq, exp_v[0]);
      end
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (bus0.readdata !== exp_v) begin
        n_fail++;
        $display("FAIL irq_data k=%0d: got %h want %h", k, bus0.readdata, exp_v);
      end
    end
    bus0.address = 2'd3;
    exp_q.push_back(32'h1);
    tick();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (bus0.readdata !== exp_v) begin
      n_fail++;
      $display("FAIL irq_edge_read: got %h want %h", bus0.readdata, exp_v);
    end
    write0(2'd3, 32'h1);
    n_cmp++;
    if (bus0.irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_clear: got %b want 0", bus0.irq);
    end
  endtask

  task automatic test_edge_mask();
    reset0();
    in0 = 4'h8;
    for (int k = 1; k <= 24; k++) begin
      if (k == 13) in0 = 4'h0;
      tick();
      n_cmp++;
      if (bus0.irq !== 1'b0) begin
        n_fail++;
        $display("FAIL masked_irq k=%0d: got %b want 0", k, bus0.irq);
      end
    end
    exp_q.push_back(32'h8);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'h0);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) write0(2'd3, 32'h4);
      if (i == 2) write0(2'd3, 32'h8);
      bus0.address = 2'd3;
      tick();
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (bus0.readdata !== exp_v) begin
        n_fail++;
        $display("FAIL edge_w1c step%0d: got %h want %h", i, bus0.readdata, exp_v);
      end
    end
  endtask

  task automatic test_w1c_race();
    reset0();
    write0(2'd2, 32'h2);
    in0 = 4'h2;
    repeat (10) tick();
    n_cmp++;
    if (bus0.irq !== 1'b1) begin
      n_fail++;
      $display("FAIL race_first_edge: got %b want 1", bus0.irq);
    end
    in0 = 4'h0;
    repeat (9) tick();
    write0(2'd3, 32'h2);
    n_cmp++;
    if (bus0.irq !== 1'b1) begin
      n_fail++;
      $display("FAIL race_irq: got %b want 1", bus0.irq);
    end
    bus0.address = 2'd3;
    exp_q.push_back(32'h2);
    tick();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (bus0.readdata !== exp_v) begin
      n_fail++;
      $display("FAIL race_edge: got %h want %h", bus0.readdata, exp_v);
    end
    write0(2'd3, 32'h2);
    n_cmp++;
    if (bus0.irq !== 1'b0) begin
      n_fail++;
      $display("FAIL race_final_clear: got %b want 0", bus0.irq);
    end
  endtask

  task automatic test_rise_only();
    reset1();
    in1 = 4'h1;
    repeat (12) tick();
    bus1.address = 2'd3;
    exp_q.push_back(32'h1);
    tick();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (bus1.readdata !== exp_v) begin
      n_fail++;
      $display("FAIL rise_capture: got %h want %h", bus1.readdata, exp_v);
    end
    write1(2'd3, 32'h1);
    in1 = 4'h0;
    repeat (12) tick();
    bus1.address = 2'd3;
    exp_q.push_back(32'h0);
    tick();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (bus1.readdata !== exp_v) begin
      n_fail++;
      $display("FAIL fall_ignored: got %h want %h", bus1.readdata, exp_v);
    end

    // Abort a debounce at count 5, then let the input fall back.
    in1 = 4'h1;
    repeat (7) tick();
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    in1 = 4'h0;
    bus1.address = 2'd3;
    for (int k = 1; k <= 12; k++) begin
      exp_q.push_back(32'h0);
      tick();
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (bus1.readdata !== exp_v || bus1.irq !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_edge k=%0d: got %h irq %b want %h irq 0", k, bus1.readdata,
                 bus1.irq, exp_v);
      end
    end

    // Abort again but keep input high: the full debounce time must restart from zero.
    in1 = 4'h1;
    repeat (7) tick();
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    bus1.address = 2'd0;
    for (int k = 1; k <= 11; k++) begin
      exp_q.push_back(k <= 10 ? 32'h0 : 32'h1);
      tick();
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (bus1.readdata !== exp_v) begin
        n_fail++;
        $display("FAIL midreset_restart k=%0d: got %h want %h", k, bus1.readdata, exp_v);
      end
    end
  endtask

  initial begin
    rst1 = 1'b1;
    in1  = 4'h0;
    bus1.chipselect = 1'b0;
    bus1.write_n    = 1'b1;
    bus1.address    = 2'd0;
    bus1.writedata  = 32'h0;
    test_reset();
    test_glitch();
    test_irq();
    test_edge_mask();
    test_w1c_race();
    test_rise_only();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
